ask2_modulator: RTL
===================

# ask2_modulator

Binary ASK (on-off keying) modulator that sits directly upstream of the 2ASK demodulator in the c8 modem chain. It accepts serial data bits through a valid/ready handshake, buffers up to two bits, and emits each bit as a fixed-length symbol of `SYM_LEN` clocks. During a symbol, `ask_out` carries a square-wave carrier for bit 1 and stays low for bit 0. With defaults, each 8-clock symbol carries a 1 as four carrier rising edges, which is the framing the downstream demodulator's 8-clock edge-count window expects.

## Interface
- `SYM_LEN`, default 8: clocks per symbol. Must be ≥2 and a multiple of 2·`CAR_HALF`.
- `CAR_HALF`, default 1: carrier half-period in clocks.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `din`  in  1: data bit offered upstream.
- `din_valid`  in  1: `din` is valid this cycle.
- `din_ready`  out  1: buffer can accept a bit; equals (fifo_count < 2), decoded from registered count only.
- `ask_out`  out  1: modulated output, driven from a flop.
- `sym_start`  out  1: one-clock pulse in the first clock of every symbol.
- `busy`  out  1: high while a symbol is being transmitted (state SEND).

## Operation
- **Reset values** (asynchronous, immediate): state IDLE, fifo_count 0, sym_cnt 0, car_cnt 0, phase 0, cur_bit 0. Outputs: `ask_out` 0, `sym_start` 0, `busy` 0, `din_ready` 1.
- **FIFO**
  - Depth 2, first-in first-out.
  - A push occurs on any edge where `din_valid` && `din_ready`.
  - A push is refused while count==2, even if a pop occurs on the same edge.
  - Simultaneous push and pop at count 1 leaves count at 1 and keeps order intact.
- **FSM IDLE**
  - If fifo_count>0: pop the head into cur_bit, set sym_cnt=0, car_cnt=0, phase=0, and go to SEND.
  - Otherwise stay in IDLE with `ask_out`=0.
- **FSM SEND**
  - sym_cnt increments each clock.
  - car_cnt counts 0..`CAR_HALF`-1; on wrap, phase toggles.
  - At sym_cnt==`SYM_LEN`-1:
    - If fifo_count>0, pop the next bit and restart the symbol with counters and phase cleared. There is no gap between symbols.
    - Otherwise return to IDLE.
- **Output**
  - `ask_out` = (state==SEND) & cur_bit & phase, registered so it is aligned with the symbol's cycles.
  - The carrier phase restarts at 0 for every symbol, so each 1-symbol contains exactly `SYM_LEN`/(2·`CAR_HALF`) rising edges and begins low.
- **Widths**: sym_cnt uses $clog2(`SYM_LEN`) bits and car_cnt uses max(1,$clog2(`CAR_HALF`)) bits. Wrap is by explicit compare, never by overflow.

## Timing
- **Latency**: a bit pushed at edge k into an empty FIFO while IDLE is loaded at edge k+1.
  - Its symbol occupies cycles k+1 .. k+`SYM_LEN`.
  - `sym_start` and `busy` are high starting in cycle k+1.
- **Back-to-back symbols**: the next `sym_start` occurs exactly `SYM_LEN` cycles after the previous one whenever the FIFO is non-empty at the symbol end.
- **Default waveform**: with defaults, a 1-symbol is `ask_out`=0,1,0,1,0,1,0,1 and a 0-symbol is eight zeros.
- **Throughput**: sustained one bit per `SYM_LEN` clocks. `din_ready` falls only when two bits are queued behind the current symbol.
- **Reset mid-symbol**: the partial symbol is abandoned, queued bits are discarded, and `ask_out` drops asynchronously. Normal operation resumes on the first edge after reset deasserts.
- **Input while IDLE with valid low**: no state change, outputs held low.

## Test plan
- **Reset check**: assert `reset`=0 mid-symbol with two bits queued -> `ask_out`, `busy` and `sym_start` drop immediately; after release `din_ready`=1, fifo empty, and no stale symbol is emitted.
- **Single 1**: single push of 1 at edge k with defaults -> `sym_start` in cycle k+1, `ask_out` sequence 0,1,0,1,0,1,0,1 over k+1..k+8, then `busy`=0 at k+9.
- **Streaming**: stream 1,0,1,1 with `din_valid` held high -> `sym_start` every 8 cycles with no gap; output has 4,0,4,4 rising edges per symbol, bits in order; `din_ready` deasserts once 2 bits are queued and reasserts at each pop.
- **Full FIFO**: with the FIFO full, hold `din_valid`=1 at a symbol boundary -> the pop occurs, the push is refused that edge and accepted on the next edge; no bit is duplicated or lost.
- **CAR_HALF=2**: parameter set `CAR_HALF`=2, `SYM_LEN`=8, bit 1 -> `ask_out`=0,0,1,1,0,0,1,1 (2 rising edges).
- **Loopback**: chain into the 2ASK demodulator with random 64-bit data -> demodulated bits match the transmitted sequence.

Source files
------------

// File: rtl/ask2_modulator_if.sv
// ============================================================================
// Module   : ask2_modulator_if
// Brief    : Serial bit handshake between an upstream data source and the
//            2ASK modulator (data bit, valid, ready).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ask2_modulator_if;
  logic din;
  logic din_valid;
  logic din_ready;

  // Upstream side offers bits and observes back-pressure.
  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  // Modulator side consumes bits and drives back-pressure.
  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );
endinterface

`default_nettype wire

// File: rtl/ask2_modulator.sv
// ============================================================================
// Module   : ask2_modulator
// Brief    : Binary ASK (on-off keying) modulator. Buffers up to two data
//            bits and sends each one as a SYM_LEN-clock symbol: a square
//            carrier for a 1, silence for a 0. Symbols run back to back
//            while data is queued.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ask2_modulator #(
  parameter int SYM_LEN  = 8,
  parameter int CAR_HALF = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  ask2_modulator_if.slave         in_if,
  output logic                    ask_out,
  output logic                    sym_start,
  output logic                    busy
);

  localparam int SYM_W = $clog2(SYM_LEN);
  localparam int CAR_W = (CAR_HALF > 1) ? $clog2(CAR_HALF) : 1;

  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYM_LEN - 1);
  localparam logic [CAR_W-1:0] CAR_LAST = CAR_W'(CAR_HALF - 1);
  localparam logic [SYM_W-1:0] SYM_ONE  = SYM_W'(1);
  localparam logic [CAR_W-1:0] CAR_ONE  = CAR_W'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t           state_q,     state_d;
  logic [1:0]       fifo_q,      fifo_d;       // bit 0 is the head
  logic [1:0]       fifo_count_q, fifo_count_d;
  logic             cur_bit_q,   cur_bit_d;
  logic [SYM_W-1:0] sym_cnt_q,   sym_cnt_d;
  logic [CAR_W-1:0] car_cnt_q,   car_cnt_d;
  logic             phase_q,     phase_d;
  logic             ask_q,       ask_d;
  logic             sym_start_q, sym_start_d;

  logic             w_push;
  logic             w_pop;
  logic             w_sym_end;

  // Ready comes straight from the registered count, so a full buffer refuses
  // a push even on the edge where the head is being popped.
  assign in_if.din_ready = (fifo_count_q < 2'd2);
  assign w_push          = in_if.din_valid && in_if.din_ready;
  assign w_sym_end       = (state_q == S_SEND) && (sym_cnt_q == SYM_LAST);
  assign w_pop           = (fifo_count_q != 2'd0) &&
                           ((state_q == S_IDLE) || w_sym_end);

  // Two-entry FIFO: pop shifts entry 1 down, push lands behind the survivor.
  always_comb begin
    fifo_d       = fifo_q;
    fifo_count_d = fifo_count_q + {1'b0, w_push} - {1'b0, w_pop};
    if (w_pop) begin
      fifo_d[0] = fifo_q[1];
    end
    if (w_push) begin
      if ((fifo_count_q == 2'd1) && !w_pop) begin
        fifo_d[1] = in_if.din;
      end else begin
        fifo_d[0] = in_if.din;
      end
    end
  end

  // Symbol sequencer: loads a bit, runs symbol and carrier counters, chains
  // the next symbol without a gap when data is waiting.
  always_comb begin
    state_d     = state_q;
    cur_bit_d   = cur_bit_q;
    sym_cnt_d   = sym_cnt_q;
    car_cnt_d   = car_cnt_q;
    phase_d     = phase_q;
    sym_start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_pop) begin
          state_d     = S_SEND;
          cur_bit_d   = fifo_q[0];
          sym_cnt_d   = '0;
          car_cnt_d   = '0;
          phase_d     = 1'b0;
          sym_start_d = 1'b1;
        end
      end
      S_SEND: begin
        if (sym_cnt_q == SYM_LAST) begin
          sym_cnt_d = '0;
          car_cnt_d = '0;
          phase_d   = 1'b0;
          if (w_pop) begin
            cur_bit_d   = fifo_q[0];
            sym_start_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          sym_cnt_d = sym_cnt_q + SYM_ONE;
          if (car_cnt_q == CAR_LAST) begin
            car_cnt_d = '0;
            phase_d   = ~phase_q;
          end else begin
            car_cnt_d = car_cnt_q + CAR_ONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Output computed from next-state values so the flop lines up with the
    // symbol cycle it belongs to.
    ask_d = (state_d == S_SEND) && cur_bit_d && phase_d;
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      fifo_q       <= 2'b00;
      fifo_count_q <= 2'd0;
      cur_bit_q    <= 1'b0;
      sym_cnt_q    <= '0;
      car_cnt_q    <= '0;
      phase_q      <= 1'b0;
      ask_q        <= 1'b0;
      sym_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fifo_q       <= fifo_d;
      fifo_count_q <= fifo_count_d;
      cur_bit_q    <= cur_bit_d;
      sym_cnt_q    <= sym_cnt_d;
      car_cnt_q    <= car_cnt_d;
      phase_q      <= phase_d;
      ask_q        <= ask_d;
      sym_start_q  <= sym_start_d;
    end
  end

  assign ask_out   = ask_q;
  assign sym_start = sym_start_q;
  assign busy      = (state_q == S_SEND);

endmodule

`default_nettype wire
